// File: rtl/instruction_fetch_queue.sv
// Fetch PC generator feeding a circular instruction queue with branch-prediction tags.
// Optional same-cycle bypass of an empty queue: define FETCH_QUEUE_BYPASS_EN.
module instruction_fetch_queue #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH  = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  output logic [31:0]                        imem_addr_o,
  input  logic [31:0]                        imem_rdata_i,
  input  logic                               bp_hit_i,
  input  logic                               bp_taken_i,
  input  logic [31:0]                        bp_target_i,
  input  logic                               redirect_i,
  input  logic [31:0]                        redirect_addr_i,
  input  logic                               stall_i,
  output logic                               valid_o,
  output logic [31:0]                        instr_o,
  output logic [31:0]                        pc_o,
  output logic                               pred_taken_o,
  output logic [31:0]                        pred_target_o,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } entry_t;

  entry_t             queue_mem [QUEUE_DEPTH];
  logic [31:0]        pc_q;
  logic [PTR_W-1:0]   head_q;
  logic [PTR_W-1:0]   tail_q;
  logic [CNT_W-1:0]   count_q;

  logic   pred_c;
  logic   bypass_c;
  logic   deq_c;
  logic   fetch_c;
  logic   enq_c;
  entry_t fetched_c;
  entry_t head_c;

  assign pred_c    = bp_hit_i & bp_taken_i;
  assign fetched_c = '{instr: imem_rdata_i, pc: pc_q, taken: pred_c, target: bp_target_i};
  assign head_c    = queue_mem[head_q];

`ifdef FETCH_QUEUE_BYPASS_EN
  // Empty queue and free decode: hand the fetched word straight through.
  assign bypass_c = (count_q == '0) & ~redirect_i & ~stall_i;
`else
  assign bypass_c = 1'b0;
`endif

  assign deq_c   = (count_q != '0) & ~stall_i;
  assign fetch_c = ~redirect_i & ((count_q < CNT_W'(QUEUE_DEPTH)) | deq_c);
  assign enq_c   = fetch_c & ~bypass_c;

  // PC, pointers and occupancy
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q    <= RESET_VECTOR;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (redirect_i) begin
      pc_q    <= {redirect_addr_i[31:2], 2'b00};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (fetch_c) pc_q <= pred_c ? bp_target_i : pc_q + 32'd4;
      if (deq_c)   head_q <= head_q + PTR_W'(1);
      if (enq_c)   tail_q <= tail_q + PTR_W'(1);
      if (enq_c && !deq_c)      count_q <= count_q + CNT_W'(1);
      else if (!enq_c && deq_c) count_q <= count_q - CNT_W'(1);
    end
  end

  // Entry storage carries no reset; occupancy alone qualifies it.
  always_ff @(posedge clk_i) begin
    if (enq_c) queue_mem[tail_q] <= fetched_c;
  end

  // Head presentation, NOP-filled when nothing is valid
  always_comb begin
    valid_o       = 1'b0;
    instr_o       = NOP;
    pc_o          = 32'h0;
    pred_taken_o  = 1'b0;
    pred_target_o = 32'h0;
    if (count_q != '0) begin
      valid_o       = 1'b1;
      instr_o       = head_c.instr;
      pc_o          = head_c.pc;
      pred_taken_o  = head_c.taken;
      pred_target_o = head_c.target;
    end else if (bypass_c) begin
      valid_o       = 1'b1;
      instr_o       = fetched_c.instr;
      pc_o          = fetched_c.pc;
      pred_taken_o  = fetched_c.taken;
      pred_target_o = fetched_c.target;
    end
  end

  assign imem_addr_o = pc_q;
  assign count_o     = count_q;

endmodule
